// File: rtl/gm64_pkg.sv
// Shared types for the gm64 memory self-test: BIST FSM states, pattern modes
// and the VIC palette used for the debug status colour.
package gm64_pkg;

   typedef enum logic [2:0] {
      IDLE, DELAY, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE
   } BistState;

   typedef enum logic [1:0] {
      FIXED, ADDR, WALK, CHECKER
   } BistMode;

   typedef enum logic [3:0] {
      BLACK, WHITE, RED, CYAN, PURPLE, GREEN, BLUE, YELLOW,
      ORANGE, BROWN, LIGHT_RED, DARK_GRAY, GRAY, LIGHT_GREEN, LIGHT_BLUE, LIGHT_GRAY
   } Color;

   // Debug colour for the top level: gray while testing, green/red once finished.
   function automatic Color bist_color(input logic running, input logic done, input logic pass);
      if (running)
         return GRAY;
      if (done)
         return pass ? GREEN : RED;
      return BLACK;
   endfunction

endpackage

// File: rtl/bist_pattern.sv
// Combinational data-pattern generator shared by the BIST write and compare paths.
module bist_pattern
   import gm64_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 24,
   parameter int unsigned       DATA_W    = 8,
   parameter logic [DATA_W-1:0] FIXED_PAT = DATA_W'(8'hAA)
) (
   input  BistMode             mode,
   input  logic [ADDR_W-1:0]   addr,
   input  logic                sweep,
   output logic [DATA_W-1:0]   data
);

   logic [DATA_W-1:0] alt;
   logic [DATA_W-1:0] base;

   always_comb begin
      alt = '0;
      for (int unsigned i = 0; i < DATA_W; i++)
         alt[i] = ~i[0];
      unique case (mode)
         FIXED:   base = FIXED_PAT;
         ADDR:    base = DATA_W'(addr);
         WALK:    base = DATA_W'(1) << (addr % ADDR_W'(DATA_W));
         CHECKER: base = addr[0] ? alt : ~alt;
         default: base = FIXED_PAT;
      endcase
      data = sweep ? ~base : base;
   end

endmodule

// File: rtl/mem_bist.sv
// Memory built-in self-test: write sweep then read/verify sweep over a
// programmable range through the memCtrl request/busy handshake.
module mem_bist
   import gm64_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 24,
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       START_DELAY = 50000,
   parameter int unsigned       TIMEOUT_CYC = 4096,
   parameter logic [DATA_W-1:0] FIXED_PAT   = DATA_W'(8'hAA),
   parameter bit                DUAL_SWEEP  = 1'b1,
   parameter int unsigned       ERR_W       = 16
) (
   input  logic              clkSys,
   input  logic              reset,
   input  logic              i_start,
   input  logic [1:0]        i_mode,
   input  logic [ADDR_W-1:0] i_addrFirst,
   input  logic [ADDR_W-1:0] i_addrLast,
   input  logic              i_stopOnFail,
   output logic              o_cs,
   output logic              o_write,
   output logic [ADDR_W-1:0] o_address,
   output logic [DATA_W-1:0] o_dataToWrite,
   input  logic [DATA_W-1:0] i_dataRead,
   input  logic              i_busy,
   input  logic              i_dataReady,
   output logic              o_running,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_timeout,
   output logic [ERR_W-1:0]  o_errCount,
   output logic [ADDR_W-1:0] o_failAddr,
   output logic [DATA_W-1:0] o_expected,
   output logic [DATA_W-1:0] o_actual
);

   localparam int unsigned DLY_W   = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam int unsigned DLY_END = (START_DELAY > 0) ? START_DELAY - 1 : 0;
   localparam int unsigned TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned TO_END  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   BistState          state, state_next;
   BistMode           mode;
   logic [ADDR_W-1:0] addr_first, addr_last, addr;
   logic              stop_on_fail, sweep, busy_seen;
   logic [DLY_W-1:0]  delay_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [DATA_W-1:0] pattern, read_data;
   logic              at_last, mismatch, handshake, to_expired, timing_out;

   bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIXED_PAT(FIXED_PAT)) u_pattern (
      .mode  (mode),
      .addr  (addr),
      .sweep (sweep),
      .data  (pattern)
   );

   assign at_last    = (addr == addr_last);
   assign mismatch   = (read_data != pattern);
   assign handshake  = state inside {WR_REQ, WR_WAIT, RD_REQ, RD_WAIT};
   assign to_expired = handshake && (to_cnt == TO_W'(TO_END));
   // Handshake states only reach DONE through the timeout path.
   assign timing_out = handshake && (state_next == DONE);

   always_ff @(posedge clkSys or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE:
            if (i_start)
               state_next = (i_addrLast < i_addrFirst) ? DONE : DELAY;
         DELAY:
            if (delay_cnt == DLY_W'(DLY_END))
               state_next = WR_REQ;
         WR_REQ:
            if (!i_busy)          state_next = WR_WAIT;
            else if (to_expired)  state_next = DONE;
         WR_WAIT:
            if (busy_seen && !i_busy) state_next = at_last ? RD_REQ : WR_REQ;
            else if (to_expired)      state_next = DONE;
         RD_REQ:
            if (!i_busy)          state_next = RD_WAIT;
            else if (to_expired)  state_next = DONE;
         RD_WAIT:
            if ((busy_seen || i_busy) && i_dataReady) state_next = CHECK;
            else if (to_expired)                      state_next = DONE;
         CHECK:
            if (mismatch && stop_on_fail) state_next = DONE;
            else if (at_last)             state_next = (!sweep && DUAL_SWEEP) ? WR_REQ : DONE;
            else                          state_next = RD_REQ;
         default:
            state_next = IDLE;
      endcase
   end

   // Request strobes are gated by i_busy in the same cycle so o_cs is low for exactly the accepted cycle.
   always_comb begin
      o_cs          = 1'b1;
      o_write       = 1'b0;
      o_dataToWrite = '0;
      if (state == WR_REQ && !i_busy) begin
         o_cs          = 1'b0;
         o_write       = 1'b1;
         o_dataToWrite = pattern;
      end else if (state == RD_REQ && !i_busy) begin
         o_cs = 1'b0;
      end
      o_address = addr;
      o_running = !(state inside {IDLE, DONE});
      o_done    = (state == DONE);
      o_pass    = (state == DONE) && (o_errCount == '0) && !o_timeout;
   end

   always_ff @(posedge clkSys or posedge reset) begin
      if (reset) begin
         mode         <= FIXED;
         addr_first   <= '0;
         addr_last    <= '0;
         addr         <= '0;
         stop_on_fail <= 1'b0;
         sweep        <= 1'b0;
         busy_seen    <= 1'b0;
         delay_cnt    <= '0;
         to_cnt       <= '0;
         read_data    <= '0;
         o_timeout    <= 1'b0;
         o_errCount   <= '0;
         o_failAddr   <= '0;
         o_expected   <= '0;
         o_actual     <= '0;
      end else begin
         unique case (state)
            IDLE, DONE:
               if (i_start) begin
                  mode         <= BistMode'(i_mode);
                  addr_first   <= i_addrFirst;
                  addr_last    <= i_addrLast;
                  stop_on_fail <= i_stopOnFail;
                  delay_cnt    <= '0;
                  o_timeout    <= 1'b0;
                  o_errCount   <= '0;
                  o_failAddr   <= '0;
                  o_expected   <= '0;
                  o_actual     <= '0;
               end
            DELAY: begin
               delay_cnt <= delay_cnt + DLY_W'(1);
               if (state_next == WR_REQ) begin
                  addr  <= addr_first;
                  sweep <= 1'b0;
               end
            end
            WR_REQ, RD_REQ:
               busy_seen <= i_busy;
            WR_WAIT: begin
               if (i_busy)
                  busy_seen <= 1'b1;
               if (state_next == RD_REQ)
                  addr <= addr_first;
               else if (state_next == WR_REQ)
                  addr <= addr + ADDR_W'(1);
            end
            RD_WAIT: begin
               if (i_busy)
                  busy_seen <= 1'b1;
               if (state_next == CHECK)
                  read_data <= i_dataRead;
            end
            CHECK: begin
               if (mismatch) begin
                  if (o_errCount != '1)
                     o_errCount <= o_errCount + ERR_W'(1);
                  if (o_errCount == '0) begin
                     o_failAddr <= addr;
                     o_expected <= pattern;
                     o_actual   <= read_data;
                  end
               end
               if (state_next == WR_REQ) begin
                  sweep <= 1'b1;
                  addr  <= addr_first;
               end else if (state_next == RD_REQ) begin
                  addr <= addr + ADDR_W'(1);
               end
            end
            default: ;
         endcase
         if (timing_out)
            o_timeout <= 1'b1;
         if (state_next != state || !handshake)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + TO_W'(1);
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist: memCtrl model with fault injection plus an
// access-sequence model of the whole BIST run.
module tb_mem_bist;

   logic        clkSys = 1'b0;
   logic        reset = 1'b1;
   logic        i_start = 1'b0;
   logic [1:0]  i_mode = '0;
   logic [23:0] i_addrFirst = '0, i_addrLast = '0;
   logic        i_stopOnFail = 1'b0;
   logic        o_cs, o_write;
   logic [23:0] o_address;
   logic [7:0]  o_dataToWrite;
   logic [7:0]  i_dataRead = '0;
   logic        i_busy = 1'b0, i_dataReady = 1'b0;
   logic        o_running, o_done, o_pass, o_timeout;
   logic [15:0] o_errCount;
   logic [23:0] o_failAddr;
   logic [7:0]  o_expected, o_actual;

   always #5 clkSys = ~clkSys;

   mem_bist #(
      .ADDR_W(24), .DATA_W(8), .START_DELAY(4), .TIMEOUT_CYC(16),
      .FIXED_PAT(8'hAA), .DUAL_SWEEP(1'b1), .ERR_W(16)
   ) dut (
      .clkSys(clkSys), .reset(reset), .i_start(i_start), .i_mode(i_mode),
      .i_addrFirst(i_addrFirst), .i_addrLast(i_addrLast), .i_stopOnFail(i_stopOnFail),
      .o_cs(o_cs), .o_write(o_write), .o_address(o_address), .o_dataToWrite(o_dataToWrite),
      .i_dataRead(i_dataRead), .i_busy(i_busy), .i_dataReady(i_dataReady),
      .o_running(o_running), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
      .o_errCount(o_errCount), .o_failAddr(o_failAddr), .o_expected(o_expected), .o_actual(o_actual)
   );

   typedef struct {
      bit          wr;
      logic [23:0] addr;
      logic [7:0]  data;
   } acc_t;

   int          compared = 0, mismatched = 0, acc_count = 0;
   acc_t        exp_q[$];
   logic [7:0]  wdata_q[$];
   logic [7:0]  mem [logic [23:0]];
   logic [23:0] fault_addr = '0;
   logic [7:0]  fault_mask = '0;
   bit          no_ready = 1'b0;
   int          m_err;
   logic [23:0] m_fail;
   logic [7:0]  m_exp, m_act;
   bit          m_to;

   task automatic check(input string name, input longint act, input longint req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] pat(input int mode, input longint a, input int s);
      logic [7:0] p;
      case (mode)
         0:       p = 8'hAA;
         1:       p = a[7:0];
         2:       p = 8'd1 << (a % 8);
         default: p = (a % 2 == 1) ? 8'h55 : 8'hAA;
      endcase
      return (s != 0) ? ~p : p;
   endfunction

   // Expected access list and final status for a run, from the test rules alone.
   task automatic build_model(input int mode, input longint first, input longint last, input bit stop);
      logic [7:0] p, stored;
      exp_q.delete();
      m_err = 0; m_fail = '0; m_exp = '0; m_act = '0; m_to = 1'b0;
      if (last < first) return;
      for (int s = 0; s < 2; s++) begin
         for (longint a = first; a <= last; a++)
            exp_q.push_back('{1'b1, 24'(a), pat(mode, a, s)});
         for (longint a = first; a <= last; a++) begin
            exp_q.push_back('{1'b0, 24'(a), 8'h00});
            if (no_ready) begin
               m_to = 1'b1;
               return;
            end
            p = pat(mode, a, s);
            stored = (24'(a) == fault_addr) ? (p & ~fault_mask) : p;
            if (stored != p) begin
               if (m_err == 0) begin
                  m_fail = 24'(a); m_exp = p; m_act = stored;
               end
               m_err++;
               if (stop) return;
            end
         end
      end
   endtask

   // memCtrl model: busy for 3 cycles after an accepted request, then a 1-cycle dataReady on reads.
   int          bcnt = 0;
   bit          pend = 1'b0, prd = 1'b0;
   logic [23:0] paddr = '0;
   always @(negedge clkSys) begin
      if (reset) begin
         bcnt = 0; pend = 1'b0; i_busy = 1'b0; i_dataReady = 1'b0;
      end else begin
         i_dataReady = 1'b0;
         if (pend) begin
            pend = 1'b0; i_busy = 1'b1; bcnt = 3;
         end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) begin
               i_busy = 1'b0;
               if (prd && !no_ready) begin
                  i_dataReady = 1'b1;
                  i_dataRead = mem[paddr];
               end
            end
         end else if (o_cs === 1'b0) begin
            pend = 1'b1; prd = !o_write; paddr = o_address;
            if (o_write)
               mem[o_address] = o_dataToWrite & ((o_address == fault_addr) ? ~fault_mask : 8'hFF);
         end
      end
   end

   // Every request cycle is checked against the next access the model predicts.
   always @(negedge clkSys) begin : cmp
      acc_t e;
      if (!reset && o_cs === 1'b0) begin
         compared++;
         acc_count++;
         if (o_write) wdata_q.push_back(o_dataToWrite);
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL access_unexpected: got wr=%0b addr=%h data=%h, required no access",
                     o_write, o_address, o_dataToWrite);
         end else begin
            e = exp_q.pop_front();
            if (o_write !== e.wr || o_address !== e.addr || (e.wr && o_dataToWrite !== e.data)) begin
               mismatched++;
               $display("FAIL access: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                        o_write, o_address, o_dataToWrite, e.wr, e.addr, e.data);
            end
         end
      end
   end

   task automatic start_run(input int mode, input logic [23:0] first, input logic [23:0] last,
                            input bit stop, input logic [23:0] faddr, input logic [7:0] fmask, input bit nr);
      fault_addr = faddr; fault_mask = fmask; no_ready = nr;
      wdata_q.delete();
      acc_count = 0;
      build_model(mode, longint'(first), longint'(last), stop);
      i_mode = 2'(mode); i_addrFirst = first; i_addrLast = last; i_stopOnFail = stop;
      i_start = 1'b1;
      @(negedge clkSys);
      i_start = 1'b0;
   endtask

   task automatic finish_run(input string tn, input int budget);
      int c = 0;
      while (!o_done && c < budget) begin
         @(negedge clkSys);
         c++;
      end
      check({tn, "_done"},    o_done, 1);
      check({tn, "_running"}, o_running, 0);
      check({tn, "_pass"},    o_pass, (m_err == 0 && !m_to) ? 1 : 0);
      check({tn, "_timeout"}, o_timeout, m_to);
      check({tn, "_errcnt"},  o_errCount, m_err);
      check({tn, "_failaddr"}, o_failAddr, m_fail);
      check({tn, "_expected"}, o_expected, m_exp);
      check({tn, "_actual"},  o_actual, m_act);
      repeat (8) @(negedge clkSys);
      check({tn, "_cs_idle"}, o_cs, 1);
      check({tn, "_acc_left"}, exp_q.size(), 0);
   endtask

   initial begin
      int c, lat;
      repeat (3) @(negedge clkSys);
      check("rst_cs", o_cs, 1);
      check("rst_write", o_write, 0);
      check("rst_addr", o_address, 0);
      check("rst_wdata", o_dataToWrite, 0);
      check("rst_status", {o_running, o_done, o_pass, o_timeout}, 0);
      check("rst_err", o_errCount, 0);
      check("rst_capture", {o_failAddr, o_expected, o_actual}, 0);
      reset = 1'b0;
      @(negedge clkSys);

      // A: fixed pattern, dual sweep, clean memory
      start_run(0, 24'h10, 24'h1F, 1'b0, 24'h0, 8'h00, 1'b0);
      finish_run("A", 2000);
      check("A_accesses", acc_count, 64);
      check("A_wdata_first", wdata_q[0], 8'hAA);
      check("A_wdata_sweep1", wdata_q[16], 8'h55);
      check("A_pass_lit", o_pass, 1);

      // B: checkerboard, bit 3 stuck low at 0x13, no stop
      start_run(3, 24'h10, 24'h1F, 1'b0, 24'h13, 8'h08, 1'b0);
      finish_run("B", 2000);
      check("B_accesses", acc_count, 64);
      check("B_err_lit", o_errCount, 1);
      check("B_failaddr_lit", o_failAddr, 24'h13);
      check("B_expected_lit", o_expected, 8'hAA);
      check("B_actual_lit", o_actual, 8'hA2);

      // C: same fault, stop on first failure
      start_run(3, 24'h10, 24'h1F, 1'b1, 24'h13, 8'h08, 1'b0);
      finish_run("C", 2000);
      check("C_accesses", acc_count, 52);

      // D: memCtrl never returns data
      start_run(0, 24'h20, 24'h21, 1'b0, 24'h0, 8'h00, 1'b1);
      c = 0;
      while (!(o_cs === 1'b0 && o_write === 1'b0) && c < 200) begin
         @(negedge clkSys);
         c++;
      end
      lat = 0;
      while (!o_done && lat < 100) begin
         @(negedge clkSys);
         lat++;
      end
      check("D_latency", (lat >= 15 && lat <= 19) ? 1 : 0, 1);
      finish_run("D", 50);
      check("D_timeout_lit", o_timeout, 1);
      no_ready = 1'b0;

      // E: top-of-range sweep without wrap
      start_run(1, 24'hFFFFFE, 24'hFFFFFF, 1'b0, 24'h0, 8'h00, 1'b0);
      finish_run("E", 500);
      check("E_accesses", acc_count, 8);
      check("E_wdata0", wdata_q[0], 8'hFE);
      check("E_wdata1", wdata_q[1], 8'hFF);

      // F: empty range
      start_run(0, 24'h5, 24'h4, 1'b0, 24'h0, 8'h00, 1'b0);
      finish_run("F", 10);
      check("F_accesses", acc_count, 0);
      check("F_pass_lit", o_pass, 1);

      // G: start pulse while running is ignored
      start_run(3, 24'h10, 24'h1F, 1'b0, 24'h13, 8'h08, 1'b0);
      c = 0;
      while (o_errCount == 0 && c < 2000) begin
         @(negedge clkSys);
         c++;
      end
      i_mode = 2'd0; i_addrFirst = 24'h0; i_addrLast = 24'hFF; i_stopOnFail = 1'b1;
      i_start = 1'b1;
      @(negedge clkSys);
      i_start = 1'b0;
      repeat (2) @(negedge clkSys);
      check("G_running", o_running, 1);
      check("G_err_hold", o_errCount, 1);
      check("G_failaddr_hold", o_failAddr, 24'h13);
      check("G_capture_hold", {o_expected, o_actual}, 16'hAAA2);
      finish_run("G", 2000);

      // H: reset while a write is in flight
      start_run(0, 24'h10, 24'h1F, 1'b0, 24'h0, 8'h00, 1'b0);
      c = 0;
      while (!(o_cs === 1'b0 && o_write === 1'b1) && c < 200) begin
         @(negedge clkSys);
         c++;
      end
      @(negedge clkSys);
      check("H_running_before", o_running, 1);
      reset = 1'b1;
      #1;
      check("H_cs", o_cs, 1);
      check("H_running", o_running, 0);
      check("H_done", o_done, 0);
      exp_q.delete();
      repeat (2) @(negedge clkSys);
      reset = 1'b0;
      repeat (10) @(negedge clkSys);
      check("H_idle_cs", o_cs, 1);
      check("H_idle_status", {o_running, o_done}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
